// File: rtl/vending_machine_param.sv
// Parametrised coin-credit vending controller with vend strobe, change/refund pulse train and coin rejection.
// Build option: define VENDING_CHANGE_EN to build the CHANGE state (overpayment return and cancel refund).
//
// state   | meaning
// IDLE    | no credit, accepting coins
// COLLECT | 0 < credit < PRICE, accepting coins or cancel
// VEND    | one-cycle vend strobe, coins refused
// CHANGE  | one change pulse per cycle until credit drains, coins refused
module vending_machine_param #(
  parameter int CREDIT_W    = 8,
  parameter int PRICE       = 15,
  parameter int VAL_A       = 5,
  parameter int VAL_B       = 10,
  parameter int VAL_C       = 25,
  parameter int CHANGE_UNIT = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                nw_pa,
  output logic                change_pulse,
  output logic                reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
`ifdef VENDING_CHANGE_EN
    VEND    = 2'd2,
    CHANGE  = 2'd3
`else
    VEND    = 2'd2
`endif
  } state_t;

  localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [CREDIT_W:0] PRICE_W    = (CREDIT_W+1)'(PRICE);

  state_t            state;
  logic [CREDIT_W:0] coin_val;
  logic [CREDIT_W:0] sum;

`ifdef VENDING_CHANGE_EN
  localparam logic [CREDIT_W-1:0] UNIT = CREDIT_W'(CHANGE_UNIT);
  logic change_q;
  logic unit_avail;
  assign change_pulse = change_q;
  assign unit_avail   = (credit >= UNIT);
`else
  assign change_pulse = 1'b0;
`endif

  always_comb begin
    coin_val = '0;
    case (coin)
      2'b01:   coin_val = (CREDIT_W+1)'(VAL_A);
      2'b10:   coin_val = (CREDIT_W+1)'(VAL_B);
      2'b11:   coin_val = (CREDIT_W+1)'(VAL_C);
      default: coin_val = '0;
    endcase
    sum = {1'b0, credit} + coin_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      credit <= '0;
      nw_pa  <= 1'b0;
      reject <= 1'b0;
      busy   <= 1'b0;
`ifdef VENDING_CHANGE_EN
      change_q <= 1'b0;
`endif
    end else begin
      nw_pa  <= 1'b0;
      reject <= 1'b0;
      busy   <= 1'b0;
`ifdef VENDING_CHANGE_EN
      change_q <= 1'b0;
`endif
      case (state)
        IDLE, COLLECT: begin
          if (cancel && (state == COLLECT)) begin
            reject <= (coin != 2'b00);
`ifdef VENDING_CHANGE_EN
            // refund starts pulsing on the cancel edge itself
            state <= CHANGE;
            busy  <= 1'b1;
            if (unit_avail) begin
              change_q <= 1'b1;
              credit   <= credit - UNIT;
            end else begin
              credit <= '0;
            end
`else
            state  <= IDLE;
            credit <= '0;
`endif
          end else if (coin != 2'b00) begin
            if (cancel || (sum > MAX_CREDIT)) begin
              reject <= 1'b1;
            end else if (sum >= PRICE_W) begin
              credit <= CREDIT_W'(sum - PRICE_W);
              state  <= VEND;
              nw_pa  <= 1'b1;
              busy   <= 1'b1;
            end else begin
              credit <= sum[CREDIT_W-1:0];
              state  <= COLLECT;
            end
          end
        end
        VEND: begin
          reject <= (coin != 2'b00);
`ifdef VENDING_CHANGE_EN
          if (credit != '0) begin
            state <= CHANGE;
            busy  <= 1'b1;
            if (unit_avail) begin
              change_q <= 1'b1;
              credit   <= credit - UNIT;
            end else begin
              credit <= '0;
            end
          end else begin
            state <= IDLE;
          end
`else
          credit <= '0;
          state  <= IDLE;
`endif
        end
`ifdef VENDING_CHANGE_EN
        CHANGE: begin
          reject <= (coin != 2'b00);
          if (credit == '0) begin
            state <= IDLE;
          end else begin
            busy <= 1'b1;
            // a residue smaller than one unit is forfeited without a pulse
            if (unit_avail) begin
              change_q <= 1'b1;
              credit   <= credit - UNIT;
            end else begin
              credit <= '0;
            end
          end
        end
`endif
        default: begin
          state  <= IDLE;
          credit <= '0;
        end
      endcase
    end
  end

endmodule
